// File: rtl/rf_pkg.sv
// Shared widths and port-slice helpers for the multi-port register file and the ID/WB stages.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int TAG_W_DEF  = 4;
  localparam int NUM_RD_DEF = 4;
  localparam int NUM_WR_DEF = 2;

  // Bus widths the ID (read) and WB (write) stages build their flattened buses from.
  localparam int ID_RD_ADDR_BUS_W = NUM_RD_DEF * ADDR_W_DEF;
  localparam int ID_RD_DATA_BUS_W = NUM_RD_DEF * DATA_W_DEF;
  localparam int WB_ADDR_BUS_W    = NUM_WR_DEF * ADDR_W_DEF;
  localparam int WB_DATA_BUS_W    = NUM_WR_DEF * DATA_W_DEF;
  localparam int WB_TAG_BUS_W     = NUM_WR_DEF * TAG_W_DEF;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy/tag scoreboard: flush beats issue-set, issue-set beats tag-matching writeback clear.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*TAG_W-1:0]  wr_tag_i,
  input  logic [NUM_WR-1:0]        iss_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] iss_addr_i,
  input  logic [NUM_WR*TAG_W-1:0]  iss_tag_i,
  input  logic                     flush_i,
  output logic [(2**ADDR_W)-1:0]   busy_o,
  output logic [(2**ADDR_W)-1:0]   clr_hit_o,
  output logic [ADDR_W-1:0]        busy_cnt_o
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy_q, busy_d, set_hit;
  logic [TAG_W-1:0]    tag_q   [NUM_REGS];
  logic [TAG_W-1:0]    tag_d   [NUM_REGS];
  logic [TAG_W-1:0]    set_tag [NUM_REGS];
  logic [ADDR_W-1:0]   busy_cnt_q, busy_cnt_d;

  // Ascending port order lets the youngest issue port overwrite the tag of older ones.
  always_comb begin
    clr_hit_o = '0;
    set_hit   = '0;
    for (int r = 0; r < NUM_REGS; r++) set_tag[r] = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_en_i[k] && wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W] == ADDR_W'(r) &&
            busy_q[r] && tag_q[r] == wr_tag_i[slice_lo(k, TAG_W) +: TAG_W])
          clr_hit_o[r] = 1'b1;
        if (iss_en_i[k] && iss_addr_i[slice_lo(k, ADDR_W) +: ADDR_W] == ADDR_W'(r)) begin
          set_hit[r] = 1'b1;
          set_tag[r] = iss_tag_i[slice_lo(k, TAG_W) +: TAG_W];
        end
      end
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_d[r] = busy_q[r];
      tag_d[r]  = tag_q[r];
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (set_hit[r]) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = set_tag[r];
      end else if (clr_hit_o[r]) begin
        busy_d[r] = 1'b0;
      end
      busy_cnt_d = busy_cnt_d + ADDR_W'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) tag_q[r] <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      for (int r = 0; r < NUM_REGS; r++) tag_q[r] <= tag_d[r];
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write bypass and an integrated busy scoreboard; r0 is hardwired to zero.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*TAG_W-1:0]  wr_tag,
  input  logic [NUM_WR-1:0]        iss_en,
  input  logic [NUM_WR*ADDR_W-1:0] iss_addr,
  input  logic [NUM_WR*TAG_W-1:0]  iss_tag,
  input  logic                     flush,
  output logic [ADDR_W-1:0]        busy_cnt
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec, clr_hit;
  logic [NUM_WR-1:0]   byp_en;

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_tag_i   (wr_tag),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .iss_tag_i  (iss_tag),
    .flush_i    (flush),
    .busy_o     (busy_vec),
    .clr_hit_o  (clr_hit),
    .busy_cnt_o (busy_cnt)
  );

  // Later non-blocking assignments win, so the highest write port takes a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[slice_lo(k, ADDR_W) +: ADDR_W] != '0)
          mem_q[wr_addr[slice_lo(k, ADDR_W) +: ADDR_W]] <= wr_data[slice_lo(k, DATA_W) +: DATA_W];
      end
    end
  end

  // Forwarding is gated by reset so reads stay zero while rst_n is low.
  assign byp_en = (BYPASS != 0) ? (wr_en & {NUM_WR{rst_n}}) : '0;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_addr[slice_lo(i, ADDR_W) +: ADDR_W] != '0) begin
        rd_data[slice_lo(i, DATA_W) +: DATA_W] = mem_q[rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]];
        rd_busy[i] = busy_vec[rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]];
        for (int k = 0; k < NUM_WR; k++) begin
          if (byp_en[k] &&
              wr_addr[slice_lo(k, ADDR_W) +: ADDR_W] == rd_addr[slice_lo(i, ADDR_W) +: ADDR_W])
            rd_data[slice_lo(i, DATA_W) +: DATA_W] = wr_data[slice_lo(k, DATA_W) +: DATA_W];
        end
        if (BYPASS != 0 && clr_hit[rd_addr[slice_lo(i, ADDR_W) +: ADDR_W]])
          rd_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus and are checked against an array model.
module tb_reg_file_mp;

  localparam int DW = 32, AW = 5, NRD = 4, NWR = 2, TW = 4, NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data1, rd_data0;
  logic [NRD-1:0]    rd_busy1, rd_busy0;
  logic [NWR-1:0]    wr_en, iss_en;
  logic [NWR*AW-1:0] wr_addr, iss_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR*TW-1:0] wr_tag, iss_tag;
  logic              flush;
  logic [AW-1:0]     busy_cnt1, busy_cnt0;

  logic [AW-1:0] rdAddr  [NRD];
  logic          wrEn    [NWR];
  logic [AW-1:0] wrAddr  [NWR];
  logic [DW-1:0] wrData  [NWR];
  logic [TW-1:0] wrTag   [NWR];
  logic          issEn   [NWR];
  logic [AW-1:0] issAddr [NWR];
  logic [TW-1:0] issTag  [NWR];
  logic          flushIn;

  logic [DW-1:0] mRegs [NR];
  bit            mBusy [NR];
  logic [TW-1:0] mTag  [NR];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Flatten the per-port stimulus arrays onto the DUT buses.
  always_comb begin
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_tag = '0;
    iss_en = '0; iss_addr = '0; iss_tag = '0;
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = rdAddr[i];
    for (int k = 0; k < NWR; k++) begin
      wr_en[k] = wrEn[k];
      wr_addr[k*AW +: AW] = wrAddr[k];
      wr_data[k*DW +: DW] = wrData[k];
      wr_tag[k*TW +: TW] = wrTag[k];
      iss_en[k] = issEn[k];
      iss_addr[k*AW +: AW] = issAddr[k];
      iss_tag[k*TW +: TW] = issTag[k];
    end
    flush = flushIn;
  end

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .TAG_W(TW), .BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag), .flush(flush), .busy_cnt(busy_cnt1));

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .TAG_W(TW), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag), .flush(flush), .busy_cnt(busy_cnt0));

  function automatic logic [DW-1:0] expData(input int a, input bit byp);
    logic [DW-1:0] d;
    if (a == 0) return '0;
    d = mRegs[a];
    if (byp)
      for (int k = 0; k < NWR; k++)
        if (wrEn[k] && int'(wrAddr[k]) == a) d = wrData[k];
    return d;
  endfunction

  function automatic bit expBusy(input int a, input bit byp);
    if (a == 0 || !mBusy[a]) return 1'b0;
    if (byp)
      for (int k = 0; k < NWR; k++)
        if (wrEn[k] && int'(wrAddr[k]) == a && wrTag[k] == mTag[a]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int expCnt();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(mBusy[r]);
    return n;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NR; r++) begin
      mRegs[r] = '0; mBusy[r] = 1'b0; mTag[r] = '0;
    end
  endtask

  // Clears are judged against the old state, then issues (unless flushed) override them.
  task automatic modelCommit();
    bit            nb [NR];
    logic [TW-1:0] nt [NR];
    nb = mBusy;
    nt = mTag;
    for (int k = 0; k < NWR; k++) begin
      if (wrEn[k] && wrAddr[k] != 0) begin
        if (mBusy[wrAddr[k]] && mTag[wrAddr[k]] == wrTag[k]) nb[wrAddr[k]] = 1'b0;
        mRegs[wrAddr[k]] = wrData[k];
      end
    end
    if (flushIn) begin
      for (int r = 0; r < NR; r++) nb[r] = 1'b0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (issEn[k] && issAddr[k] != 0) begin
          nb[issAddr[k]] = 1'b1;
          nt[issAddr[k]] = issTag[k];
        end
    end
    mBusy = nb;
    mTag  = nt;
  endtask

  task automatic idle();
    for (int i = 0; i < NRD; i++) rdAddr[i] = '0;
    for (int k = 0; k < NWR; k++) begin
      wrEn[k] = 1'b0; wrAddr[k] = '0; wrData[k] = '0; wrTag[k] = '0;
      issEn[k] = 1'b0; issAddr[k] = '0; issTag[k] = '0;
    end
    flushIn = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelCommit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    modelReset();
    @(negedge clk);
    for (int g = 0; g < NR / NRD; g++) begin
      for (int i = 0; i < NRD; i++) rdAddr[i] = AW'(g * NRD + i);
      #1;
      for (int i = 0; i < NRD; i++) begin
        checks++;
        if ({rd_data1[i*DW +: DW], rd_data0[i*DW +: DW], rd_busy1[i], rd_busy0[i]} !== '0) begin
          errors++;
          $display("[TB] FAIL reset_read r%0d got d1=%h d0=%h b1=%b b0=%b exp 0", g*NRD+i,
                   rd_data1[i*DW +: DW], rd_data0[i*DW +: DW], rd_busy1[i], rd_busy0[i]);
        end
      end
    end
    checks++;
    if (busy_cnt1 !== 5'd0 || busy_cnt0 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt got %0d/%0d exp 0", busy_cnt1, busy_cnt0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_priority();
    idle();
    wrEn[0] = 1'b1; wrAddr[0] = 5'd5; wrData[0] = 32'h11;
    wrEn[1] = 1'b1; wrAddr[1] = 5'd5; wrData[1] = 32'h22;
    rdAddr[0] = 5'd5;
    #1;
    checks++;
    if (rd_data1[0 +: DW] !== 32'h22 || rd_data0[0 +: DW] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wprio_same got byp=%h nobyp=%h exp 22/0", rd_data1[0 +: DW], rd_data0[0 +: DW]);
    end
    tick();
    idle();
    rdAddr[0] = 5'd5;
    #1;
    checks++;
    if (rd_data1[0 +: DW] !== 32'h22 || rd_data0[0 +: DW] !== 32'h22) begin
      errors++;
      $display("[TB] FAIL wprio_next got byp=%h nobyp=%h exp 22/22", rd_data1[0 +: DW], rd_data0[0 +: DW]);
    end
  endtask

  task automatic test_issue_clear();
    idle();
    issEn[0] = 1'b1; issAddr[0] = 5'd7; issTag[0] = 4'd3;
    rdAddr[0] = 5'd7;
    #1;
    checks++;
    if (rd_busy1[0] !== 1'b0 || busy_cnt1 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL iss_same_cycle got busy=%b cnt=%0d exp 0/0", rd_busy1[0], busy_cnt1);
    end
    tick();
    idle();
    rdAddr[0] = 5'd7;
    #1;
    checks++;
    if (rd_busy1[0] !== 1'b1 || rd_busy0[0] !== 1'b1 || busy_cnt1 !== 5'd1) begin
      errors++;
      $display("[TB] FAIL iss_visible got b1=%b b0=%b cnt=%0d exp 1/1/1", rd_busy1[0], rd_busy0[0], busy_cnt1);
    end
    wrEn[0] = 1'b1; wrAddr[0] = 5'd7; wrData[0] = 32'h77; wrTag[0] = 4'd2;
    #1;
    checks++;
    if (rd_busy1[0] !== 1'b1 || rd_data1[0 +: DW] !== 32'h77) begin
      errors++;
      $display("[TB] FAIL wb_tag_mismatch got busy=%b data=%h exp 1/77", rd_busy1[0], rd_data1[0 +: DW]);
    end
    tick();
    idle();
    rdAddr[0] = 5'd7;
    wrEn[0] = 1'b1; wrAddr[0] = 5'd7; wrData[0] = 32'h78; wrTag[0] = 4'd3;
    #1;
    checks++;
    if (rd_data0[0 +: DW] !== 32'h77 || rd_busy0[0] !== 1'b1 || rd_busy1[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wb_tag_match got d0=%h b0=%b b1=%b exp 77/1/0", rd_data0[0 +: DW], rd_busy0[0], rd_busy1[0]);
    end
    tick();
    idle();
    rdAddr[0] = 5'd7;
    #1;
    checks++;
    if (rd_busy0[0] !== 1'b0 || busy_cnt1 !== 5'd0 || busy_cnt0 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL wb_cleared got b0=%b cnt=%0d/%0d exp 0/0/0", rd_busy0[0], busy_cnt1, busy_cnt0);
    end
  endtask

  task automatic test_set_wins();
    idle();
    issEn[0] = 1'b1; issAddr[0] = 5'd9; issTag[0] = 4'd1;
    tick();
    wrEn[0] = 1'b1; wrAddr[0] = 5'd9; wrData[0] = 32'h99; wrTag[0] = 4'd1;
    tick();
    idle();
    rdAddr[0] = 5'd9;
    #1;
    checks++;
    if (rd_busy1[0] !== 1'b1 || busy_cnt1 !== 5'd1) begin
      errors++;
      $display("[TB] FAIL set_beats_clear got busy=%b cnt=%0d exp 1/1", rd_busy1[0], busy_cnt1);
    end
    wrEn[0] = 1'b1; wrAddr[0] = 5'd9; wrData[0] = 32'h9A; wrTag[0] = 4'd1;
    #1;
    checks++;
    if (rd_busy1[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL set_tag_kept got busy=%b exp 0", rd_busy1[0]);
    end
    tick();
    idle();
    issEn[0] = 1'b1; issAddr[0] = 5'd4; issTag[0] = 4'd5;
    issEn[1] = 1'b1; issAddr[1] = 5'd4; issTag[1] = 4'd6;
    tick();
    idle();
    rdAddr[0] = 5'd4;
    wrEn[0] = 1'b1; wrAddr[0] = 5'd4; wrData[0] = 32'h44; wrTag[0] = 4'd5;
    #1;
    checks++;
    if (rd_busy1[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL iss_prio_old_tag got busy=%b exp 1", rd_busy1[0]);
    end
    tick();
    wrTag[0] = 4'd6;
    #1;
    checks++;
    if (rd_busy1[0] !== 1'b0 || rd_busy0[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL iss_prio_young_tag got b1=%b b0=%b exp 0/1", rd_busy1[0], rd_busy0[0]);
    end
    tick();
    idle();
    rdAddr[0] = 5'd4;
    #1;
    checks++;
    if (rd_busy0[0] !== 1'b0 || busy_cnt0 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL iss_prio_cleared got busy=%b cnt=%0d exp 0/0", rd_busy0[0], busy_cnt0);
    end
  endtask

  task automatic test_flush();
    idle();
    for (int c = 0; c < 3; c++) begin
      issEn[0] = 1'b1; issAddr[0] = AW'(2*c + 1); issTag[0] = TW'(c);
      issEn[1] = 1'b1; issAddr[1] = AW'(2*c + 2); issTag[1] = TW'(c + 8);
      tick();
    end
    idle();
    #1;
    checks++;
    if (busy_cnt1 !== 5'd6 || busy_cnt0 !== 5'd6) begin
      errors++;
      $display("[TB] FAIL flush_pre_cnt got %0d/%0d exp 6", busy_cnt1, busy_cnt0);
    end
    flushIn = 1'b1;
    issEn[0] = 1'b1; issAddr[0] = 5'd10; issTag[0] = 4'd2;
    wrEn[0] = 1'b1; wrAddr[0] = 5'd2; wrData[0] = 32'hAB; wrTag[0] = 4'd9;
    tick();
    idle();
    rdAddr[0] = 5'd10; rdAddr[1] = 5'd2;
    #1;
    checks++;
    if (busy_cnt1 !== 5'd0 || busy_cnt0 !== 5'd0 || rd_busy1[0] !== 1'b0 || rd_busy0[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_busy got cnt=%0d/%0d b10=%b b2=%b exp 0", busy_cnt1, busy_cnt0, rd_busy1[0], rd_busy0[1]);
    end
    checks++;
    if (rd_data1[DW +: DW] !== 32'hAB || rd_data0[DW +: DW] !== 32'hAB) begin
      errors++;
      $display("[TB] FAIL flush_wb_data got %h/%h exp ab", rd_data1[DW +: DW], rd_data0[DW +: DW]);
    end
  endtask

  task automatic test_r0();
    idle();
    wrEn[0] = 1'b1; wrAddr[0] = 5'd0; wrData[0] = 32'hFFFF_FFFF;
    issEn[1] = 1'b1; issAddr[1] = 5'd0; issTag[1] = 4'd1;
    #1;
    checks++;
    if (rd_data1[0 +: DW] !== 32'h0 || rd_busy1[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r0_same got data=%h busy=%b exp 0/0", rd_data1[0 +: DW], rd_busy1[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data0[0 +: DW] !== 32'h0 || rd_busy0[0] !== 1'b0 || rd_busy1[0] !== 1'b0 || busy_cnt1 !== 5'd0) begin
      errors++;
      $display("[TB] FAIL r0_next got data=%h b0=%b b1=%b cnt=%0d exp 0", rd_data0[0 +: DW], rd_busy0[0], rd_busy1[0], busy_cnt1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NRD; i++) rdAddr[i] = AW'($urandom_range(0, 15));
      for (int k = 0; k < NWR; k++) begin
        wrEn[k]    = 1'($urandom_range(0, 1));
        wrAddr[k]  = AW'($urandom_range(0, 15));
        wrData[k]  = $urandom;
        wrTag[k]   = TW'($urandom_range(0, 3));
        issEn[k]   = ($urandom_range(0, 2) == 0);
        issAddr[k] = AW'($urandom_range(0, 15));
        issTag[k]  = TW'($urandom_range(0, 3));
      end
      flushIn = ($urandom_range(0, 24) == 0);
      #1;
      for (int i = 0; i < NRD; i++) begin
        checks++;
        if (rd_data1[i*DW +: DW] !== expData(int'(rdAddr[i]), 1'b1) ||
            rd_busy1[i] !== expBusy(int'(rdAddr[i]), 1'b1)) begin
          errors++;
          $display("[TB] FAIL rand_byp cyc%0d port%0d r%0d got %h/%b exp %h/%b", n, i, rdAddr[i],
                   rd_data1[i*DW +: DW], rd_busy1[i], expData(int'(rdAddr[i]), 1'b1), expBusy(int'(rdAddr[i]), 1'b1));
        end
        checks++;
        if (rd_data0[i*DW +: DW] !== expData(int'(rdAddr[i]), 1'b0) ||
            rd_busy0[i] !== expBusy(int'(rdAddr[i]), 1'b0)) begin
          errors++;
          $display("[TB] FAIL rand_nobyp cyc%0d port%0d r%0d got %h/%b exp %h/%b", n, i, rdAddr[i],
                   rd_data0[i*DW +: DW], rd_busy0[i], expData(int'(rdAddr[i]), 1'b0), expBusy(int'(rdAddr[i]), 1'b0));
        end
      end
      checks++;
      if (int'(busy_cnt1) != expCnt() || int'(busy_cnt0) != expCnt()) begin
        errors++;
        $display("[TB] FAIL rand_cnt cyc%0d got %0d/%0d exp %0d", n, busy_cnt1, busy_cnt0, expCnt());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    flushIn = 1'b1;
    tick();
    idle();
    issEn[0] = 1'b1; issAddr[0] = 5'd11; issTag[0] = 4'd1;
    issEn[1] = 1'b1; issAddr[1] = 5'd12; issTag[1] = 4'd2;
    wrEn[0] = 1'b1; wrAddr[0] = 5'd20; wrData[0] = 32'hDEAD;
    tick();
    idle();
    issEn[0] = 1'b1; issAddr[0] = 5'd13; issTag[0] = 4'd3;
    tick();
    idle();
    rdAddr[0] = 5'd20; rdAddr[1] = 5'd11;
    #1;
    checks++;
    if (busy_cnt1 !== 5'd3 || rd_data0[0 +: DW] !== 32'hDEAD || rd_busy0[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arst_pre got cnt=%0d data=%h busy=%b exp 3/dead/1", busy_cnt1, rd_data0[0 +: DW], rd_busy0[1]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_cnt1 !== 5'd0 || busy_cnt0 !== 5'd0 || rd_data1[0 +: DW] !== 32'h0 ||
        rd_data0[0 +: DW] !== 32'h0 || rd_busy1[1] !== 1'b0 || rd_busy0[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_immediate got cnt=%0d/%0d d=%h/%h b=%b/%b exp 0", busy_cnt1, busy_cnt0,
               rd_data1[0 +: DW], rd_data0[0 +: DW], rd_busy1[1], rd_busy0[1]);
    end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_write_priority();
    test_issue_clear();
    test_set_wins();
    test_flush();
    test_r0();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
